// File: rtl/axis_segmenter_if.sv
// AXI-Stream bundle used on both sides of the segmenter.
// tuser exists only when AXIS_SEGMENTER_ORIG_LAST_EN is defined.
interface axis_segmenter_if #(parameter int DW = 512);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
  logic            tuser;
`endif

  modport master (
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
    output tuser,
`endif
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
    input  tuser,
`endif
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_segmenter.sv
// Splits AXI-Stream packets into segments of at most seg_len beats by forcing TLAST.
// Optional AXIS_SEGMENTER_ORIG_LAST_EN: m_axis.tuser flags beats carrying the original TLAST.
module axis_segmenter #(
  parameter int DW = 512,
  parameter int LW = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [LW-1:0]     seg_len,
  axis_segmenter_if.slave   s_axis,
  axis_segmenter_if.master  m_axis,
  output logic [31:0]       seg_count
);
  localparam int KW = DW / 8;

  logic          acc, m_fire, forced, fwd_last;
  logic [LW-1:0] eff_lim;
  logic [LW-1:0] cnt_q, cnt_d, lim_q, lim_d;
  logic          rdy_q, rdy_d;
  logic          out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [KW-1:0] out_keep_q, out_keep_d;
  logic          skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic [KW-1:0] skid_keep_q, skid_keep_d;
  logic [31:0]   seg_cnt_q, seg_cnt_d;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
  logic          out_user_q, out_user_d, skid_user_q, skid_user_d;
`endif

  assign acc    = s_axis.tvalid & rdy_q;
  assign m_fire = out_vld_q & m_axis.tready;

  // Segment boundary is decided at the input acceptance point; seg_len is
  // taken live on the first beat of a segment and latched for the rest of it.
  always_comb begin
    eff_lim  = (cnt_q == '0) ? seg_len : lim_q;
    forced   = (eff_lim != '0) && (cnt_q == eff_lim - LW'(1));
    fwd_last = s_axis.tlast | forced;
    cnt_d    = cnt_q;
    lim_d    = lim_q;
    if (acc) begin
      if (cnt_q == '0) lim_d = seg_len;
      if (fwd_last)          cnt_d = '0;
      else if (cnt_q != '1) cnt_d = cnt_q + LW'(1);  // saturate so pass-through never wraps
    end
  end

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_keep_d = skid_keep_q;
    skid_last_d = skid_last_q;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
    out_user_d  = out_user_q;
    skid_user_d = skid_user_q;
`endif
    if (!out_vld_q || m_fire) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        out_keep_d = skid_keep_q;
        out_last_d = skid_last_q;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
        out_user_d = skid_user_q;
`endif
        skid_vld_d = 1'b0;
      end else if (acc) begin
        out_vld_d  = 1'b1;
        out_data_d = s_axis.tdata;
        out_keep_d = s_axis.tkeep;
        out_last_d = fwd_last;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
        out_user_d = s_axis.tlast;
`endif
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (acc) begin
      skid_vld_d  = 1'b1;
      skid_data_d = s_axis.tdata;
      skid_keep_d = s_axis.tkeep;
      skid_last_d = fwd_last;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
      skid_user_d = s_axis.tlast;
`endif
    end
    rdy_d     = ~skid_vld_d;
    seg_cnt_d = seg_cnt_q + {31'd0, m_fire & out_last_q};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q       <= '0;
      lim_q       <= '0;
      rdy_q       <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_keep_q <= '0;
      skid_last_q <= 1'b0;
      seg_cnt_q   <= '0;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
      out_user_q  <= 1'b0;
      skid_user_q <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      rdy_q       <= rdy_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_keep_q <= skid_keep_d;
      skid_last_q <= skid_last_d;
      seg_cnt_q   <= seg_cnt_d;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
      out_user_q  <= out_user_d;
      skid_user_q <= skid_user_d;
`endif
    end
  end

  assign s_axis.tready = rdy_q;
  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tkeep  = out_keep_q;
  assign m_axis.tlast  = out_last_q;
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
  assign m_axis.tuser  = out_user_q;
`endif
  assign seg_count     = seg_cnt_q;
endmodule

// File: tb/tb_axis_segmenter.sv
// Scoreboard bench for axis_segmenter: reference segment model at the input,
// in-order compare at the output, AXI hold and skid-ready checks.
module tb_axis_segmenter;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [LW-1:0] seg_len;
  logic [31:0]   seg_count;

  axis_segmenter_if #(.DW(DW)) s_if ();
  axis_segmenter_if #(.DW(DW)) m_if ();

  axis_segmenter #(.DW(DW), .LW(LW)) dut (
    .aclk(aclk), .aresetn(aresetn), .seg_len(seg_len),
    .s_axis(s_if), .m_axis(m_if), .seg_count(seg_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] k;
    logic            l;
    logic            u;
    int              c;
  } exp_t;

  exp_t          q[$];
  int            n_chk = 0, n_fail = 0;
  int            cyc = 0;
  int            mcnt = 0, mlim = 0;
  logic          mon_en = 1'b0, lat_chk = 1'b0, rnd_rdy = 1'b0, rdy_hold = 1'b1;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output ready driver
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_hold;
    end
  end

  // Monitor: decisions taken at negedge apply to the following posedge
  initial begin
    logic        stall = 1'b0;
    logic [63:0] held = '0;
    exp_t        e;
    forever begin
      @(negedge aclk);
      if (!mon_en) stall = 1'b0;
      else begin
        if (stall) begin
          chk("hold_vld", 64'(m_if.tvalid), 64'd1);
          chk("hold_payload", 64'({m_if.tdata, m_if.tkeep, m_if.tlast}), held);
        end
        stall = m_if.tvalid && !m_if.tready;
        held  = 64'({m_if.tdata, m_if.tkeep, m_if.tlast});
        if (!s_if.tready) chk("rdy_low_outfull", 64'(m_if.tvalid), 64'd1);
        if (m_if.tvalid && m_if.tready) begin
          if (q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("data", 64'(m_if.tdata), 64'(e.d));
            chk("keep", 64'(m_if.tkeep), 64'(e.k));
            chk("last", 64'(m_if.tlast), 64'(e.l));
`ifdef AXIS_SEGMENTER_ORIG_LAST_EN
            chk("user", 64'(m_if.tuser), 64'(e.u));
`endif
            if (lat_chk) chk("latency", 64'(cyc), 64'(e.c + 1));
          end
        end
      end
    end
  end

  // Sends beats 1..nsend of an n-beat packet; seg_len switches to lb from beat chg (0 = never).
  task automatic send_pkt(input int n, input int nsend, input int la, input int chg, input int lb);
    exp_t e;
    int   eff;
    logic forced;
    for (int i = 1; i <= nsend; i++) begin
      s_if.tdata  = DW'($urandom);
      s_if.tkeep  = 4'($urandom);
      s_if.tlast  = (i == n);
      s_if.tvalid = 1'b1;
      seg_len     = LW'((chg != 0 && i >= chg) ? lb : la);
      for (int w = 0; ; w++) begin
        @(negedge aclk);
        if (s_if.tready) break;
        if (w > 2000) begin chk("drv_timeout", 64'd1, 64'd0); break; end
      end
      eff    = (mcnt == 0) ? int'(seg_len) : mlim;
      forced = (eff != 0) && (mcnt == eff - 1);
      if (mcnt == 0) mlim = int'(seg_len);
      e.d = s_if.tdata; e.k = s_if.tkeep; e.l = s_if.tlast | forced; e.u = s_if.tlast; e.c = cyc;
      q.push_back(e);
      mcnt = e.l ? 0 : mcnt + 1;
      @(posedge aclk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input string tag, input int exp_segs);
    for (int w = 0; q.size() != 0 && w < 3000; w++) @(posedge aclk);
    chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    @(posedge aclk); #1;
    chk({tag, "_segcnt"}, 64'(seg_count), 64'(exp_segs));
  endtask

  initial begin
    aresetn = 1'b0; seg_len = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    repeat (3) @(posedge aclk); #1;
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tready", 64'(s_if.tready), 64'd0);
    chk("rst_segcnt", 64'(seg_count), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_tready", 64'(s_if.tready), 64'd1);
    chk("post_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("post_rst_payload", 64'({m_if.tdata, m_if.tkeep, m_if.tlast}), 64'd0);
    mon_en = 1'b1;

    lat_chk = 1'b1;
    send_pkt(10, 10, 4, 0, 0);  drain("len4_10", 3);
    send_pkt(8, 8, 4, 0, 0);    drain("len4_8", 5);
    send_pkt(3, 3, 0, 0, 0);
    send_pkt(100, 100, 0, 0, 0); drain("passthru", 7);

    lat_chk = 1'b0; rnd_rdy = 1'b1;
    send_pkt(30, 30, 3, 0, 0);  drain("rand_rdy", 17);
    rnd_rdy = 1'b0; rdy_hold = 1'b1;
    @(posedge aclk); #1;

    lat_chk = 1'b1;
    send_pkt(9, 9, 4, 2, 2);    drain("len_change", 21);
    send_pkt(3, 3, 1, 0, 0);    drain("len1", 24);

    lat_chk = 1'b0; rdy_hold = 1'b0; m_if.tready = 1'b0;
    send_pkt(4, 2, 4, 0, 0);
    mon_en = 1'b0;
    aresetn = 1'b0; #1;
    chk("midrst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("midrst_tready", 64'(s_if.tready), 64'd0);
    chk("midrst_segcnt", 64'(seg_count), 64'd0);
    q.delete(); mcnt = 0; mlim = 0;
    @(posedge aclk); #1;
    aresetn = 1'b1; rdy_hold = 1'b1;
    @(posedge aclk); #1;
    chk("midrst_ready_back", 64'(s_if.tready), 64'd1);
    mon_en = 1'b1;
    send_pkt(4, 4, 4, 0, 0);    drain("after_rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
